depth_conv_result_writer: RTL and testbench

DEPTH_CONV_RESULT_WRITER -- requirements
Module: depth_conv_result_writer

---
 rtl/depth_conv_result_writer_pkg.sv | 43 ++++
 rtl/depth_conv_result_writer_fifo.sv | 95 +++++++++
 rtl/depth_conv_result_writer.sv | 186 ++++++++++++++++++
 tb/tb_depth_conv_result_writer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/depth_conv_result_writer_pkg.sv
// Shared NPU constants, FSM encoding and the
// per-lane psum-to-int8 quantizer.
package depth_conv_result_writer_pkg;

  localparam logic [3:0] DEPTH_CONV_MODE = 4'd6;
  localparam int PE_NUM_DEF = 8;
  localparam int RES_W      = 8;
  localparam int ADDR_W     = 13;
  localparam int CNT_W      = 21;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [RES_W-1:0] quantize(
    input logic signed [31:0] v,
    input logic        [3:0]  sh,
    input logic               relu,
    input logic               en
  );
    logic signed [31:0] s;
    logic [RES_W-1:0]   r;
    s = v >>> sh;
    if (relu && (s < 0)) begin
      s = '0;
    end
    if (s > 32'sd127) begin
      r = 8'h7f;
    end else if (s < -32'sd128) begin
      r = 8'h80;
    end else begin
      r = s[RES_W-1:0];
    end
    if (!en) begin
      r = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/depth_conv_result_writer_fifo.sv
// Result FIFO: width/depth parameterised, clearable,
// with a sticky drop flag for pushes into a full queue.
module result_fifo
  import depth_conv_result_writer_pkg::*;
#(
  parameter int W     = 72,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign overflow = ovf_q;
  assign dout     = mem_q[rptr_q];

  // a pop frees the slot a same-cycle push needs
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = din;
        wptr_d        = nxt(wptr_q);
      end
      if (do_pop) begin
        rptr_d = nxt(rptr_q);
      end
      if (push && !do_push) begin
        ovf_d = 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/depth_conv_result_writer.sv
// Depthwise result writer: quantizes PE lane sums to
// int8 and streams them into the output buffer.
module depth_conv_result_writer
  import depth_conv_result_writer_pkg::*;
#(
  parameter int PE_NUM     = PE_NUM_DEF,
  parameter int PSUM_W     = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               mode,
  input  logic                     start_calculate,
  input  logic [ADDR_W-1:0]        addr_start_o,
  input  logic [7:0]               out_y_length,
  input  logic [7:0]               in_piece,
  input  logic [4:0]               part_num,
  input  logic [3:0]               i_shift,
  input  logic                     i_relu,
  input  logic                     i_depthconv_out,
  input  logic [PE_NUM-1:0]        i_pe_en,
  input  logic [PE_NUM*PSUM_W-1:0] i_psum,
  input  logic                     i_wr_ready,
  output logic                     o_wr_en,
  output logic [ADDR_W-1:0]        o_wr_addr,
  output logic [PE_NUM*RES_W-1:0]  o_wr_data,
  output logic [PE_NUM-1:0]        o_wr_mask,
  output logic                     o_layer_done,
  output logic                     o_overflow
);

  localparam int DW = PE_NUM * RES_W;
  localparam int FW = DW + PE_NUM;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  tgt_q, tgt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  prod;
  logic [ADDR_W-1:0] waddr_q, waddr_d;

  logic                     q_vld_q, q_vld_d;
  logic [PE_NUM*PSUM_W-1:0] q_psum_q, q_psum_d;
  logic [PE_NUM-1:0]        q_en_q, q_en_d;
  logic [3:0]               q_sh_q, q_sh_d;
  logic                     q_relu_q, q_relu_d;
  logic [DW-1:0]            q_bytes;

  logic          cap;
  logic          fifo_clr;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_ovf;
  logic [FW-1:0] fifo_dout;
  logic          active;

  assign prod = CNT_W'(out_y_length)
              * CNT_W'(in_piece)
              * CNT_W'(part_num);

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    logic signed [PSUM_W-1:0] lane;
    q_bytes = '0;
    for (int k = 0; k < PE_NUM; k++) begin
      lane = q_psum_q[k*PSUM_W +: PSUM_W];
      q_bytes[k*RES_W +: RES_W] =
        quantize(32'(lane), q_sh_q,
                 q_relu_q, q_en_q[k]);
    end
  end

  assign active = (state_q == ST_RUN)
               || (state_q == ST_DRAIN);

  assign fifo_push = q_vld_q;
  assign fifo_pop  = o_wr_en && i_wr_ready;

  result_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (fifo_clr),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .din      ({q_en_q, q_bytes}),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (fifo_ovf)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    waddr_d  = fifo_pop ? waddr_q + ADDR_W'(1)
                        : waddr_q;
    fifo_clr = 1'b0;
    cap      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_calculate
            && (mode == DEPTH_CONV_MODE)) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          tgt_d    = prod;
          waddr_d  = addr_start_o;
          fifo_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (tgt_q == '0) begin
          state_d = ST_DRAIN;
        end else if (i_depthconv_out) begin
          cap   = 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc == tgt_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !q_vld_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // shift/relu travel with the sums so later
  // layer-setting changes cannot skew an entry
  always_comb begin
    q_vld_d  = cap;
    q_psum_d = cap ? i_psum   : q_psum_q;
    q_en_d   = cap ? i_pe_en  : q_en_q;
    q_sh_d   = cap ? i_shift  : q_sh_q;
    q_relu_d = cap ? i_relu   : q_relu_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      tgt_q    <= '0;
      waddr_q  <= '0;
      q_vld_q  <= 1'b0;
      q_psum_q <= '0;
      q_en_q   <= '0;
      q_sh_q   <= '0;
      q_relu_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
      waddr_q  <= waddr_d;
      q_vld_q  <= q_vld_d;
      q_psum_q <= q_psum_d;
      q_en_q   <= q_en_d;
      q_sh_q   <= q_sh_d;
      q_relu_q <= q_relu_d;
    end
  end

  assign o_wr_en      = active && !fifo_empty;
  assign o_wr_addr    = waddr_q;
  assign o_wr_data    = o_wr_en ? fifo_dout[DW-1:0]
                                : '0;
  assign o_wr_mask    = o_wr_en ? fifo_dout[DW +: PE_NUM]
                                : '0;
  assign o_layer_done = (state_q == ST_DONE);
  assign o_overflow   = fifo_ovf;

endmodule

// File: tb/tb_depth_conv_result_writer.sv
// Directed bench for depth_conv_result_writer with an
// expected-write queue model and per-cycle compare.
module tb_depth_conv_result_writer;

  localparam int PE = 8;
  localparam int PW = 20;
  localparam int FD = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     mode;
  logic           start_calculate;
  logic [12:0]    addr_start_o;
  logic [7:0]     out_y_length;
  logic [7:0]     in_piece;
  logic [4:0]     part_num;
  logic [3:0]     i_shift;
  logic           i_relu;
  logic           i_depthconv_out;
  logic [PE-1:0]  i_pe_en;
  logic [PE*PW-1:0] i_psum;
  logic           i_wr_ready;
  logic           o_wr_en;
  logic [12:0]    o_wr_addr;
  logic [PE*8-1:0] o_wr_data;
  logic [PE-1:0]  o_wr_mask;
  logic           o_layer_done;
  logic           o_overflow;

  depth_conv_result_writer #(
    .PE_NUM     (PE),
    .PSUM_W     (PW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mode            (mode),
    .start_calculate (start_calculate),
    .addr_start_o    (addr_start_o),
    .out_y_length    (out_y_length),
    .in_piece        (in_piece),
    .part_num        (part_num),
    .i_shift         (i_shift),
    .i_relu          (i_relu),
    .i_depthconv_out (i_depthconv_out),
    .i_pe_en         (i_pe_en),
    .i_psum          (i_psum),
    .i_wr_ready      (i_wr_ready),
    .o_wr_en         (o_wr_en),
    .o_wr_addr       (o_wr_addr),
    .o_wr_data       (o_wr_data),
    .o_wr_mask       (o_wr_mask),
    .o_layer_done    (o_layer_done),
    .o_overflow      (o_overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [12:0] ex_addr [$];
  logic [63:0] ex_data [$];
  logic [7:0]  ex_mask [$];
  logic [12:0] lg_addr [$];
  logic [63:0] lg_data [$];
  logic [7:0]  lg_mask [$];
  logic [12:0] m_addr;
  int          done_cnt = 0;
  logic        prev_done = 1'b0;
  int          lv [PE];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [7:0] q8(input int v,
                                    input int sh,
                                    input bit relu,
                                    input bit en);
    int r;
    r = v >>> sh;
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    if (!en) r = 0;
    return r[7:0];
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (o_wr_en && i_wr_ready) begin
        lg_addr.push_back(o_wr_addr);
        lg_data.push_back(o_wr_data);
        lg_mask.push_back(o_wr_mask);
        if (ex_addr.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h",
                   o_wr_addr, o_wr_data);
        end else begin
          check("wr_addr", o_wr_addr, ex_addr.pop_front());
          check("wr_data", o_wr_data, ex_data.pop_front());
          check("wr_mask", o_wr_mask, ex_mask.pop_front());
        end
      end
      if (o_layer_done) begin
        done_cnt++;
        check("done_single_cycle", prev_done, 0);
      end
      prev_done = o_layer_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input logic [12:0] a,
                             input logic [7:0] y,
                             input logic [7:0] p,
                             input logic [4:0] n);
    addr_start_o    = a;
    out_y_length    = y;
    in_piece        = p;
    part_num        = n;
    mode            = 4'd6;
    start_calculate = 1'b1;
    m_addr          = a;
    tick();
    start_calculate = 1'b0;
  endtask

  task automatic ev(input logic [7:0] en, input bit keep);
    logic [63:0] d;
    int t;
    d = '0;
    for (int k = 0; k < PE; k++) begin
      t = lv[k];
      i_psum[k*PW +: PW] = t[PW-1:0];
      d[k*8 +: 8] = q8(lv[k], int'(i_shift), i_relu, en[k]);
    end
    i_pe_en = en;
    i_depthconv_out = 1'b1;
    if (keep) begin
      ex_addr.push_back(m_addr);
      ex_data.push_back(d);
      ex_mask.push_back(en);
      m_addr = m_addr + 13'd1;
    end
    tick();
    i_depthconv_out = 1'b0;
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < PE; k++) lv[k] = v;
  endtask

  task automatic wait_done(input string name, input int want);
    for (int i = 0; i < 200; i++) begin
      if (done_cnt >= want) break;
      tick();
    end
    check(name, done_cnt, want);
    check({name, "_all_writes"}, ex_addr.size(), 0);
  endtask

  initial begin
    int n0;
    rst = 1'b0;
    mode = 4'd6;
    start_calculate = 0;
    addr_start_o = '0;
    out_y_length = '0;
    in_piece = '0;
    part_num = '0;
    i_shift = '0;
    i_relu = 0;
    i_depthconv_out = 0;
    i_pe_en = '0;
    i_psum = '0;
    i_wr_ready = 1'b1;
    set_all(0);
    repeat (3) tick();
    check("rst_wr_en", o_wr_en, 0);
    check("rst_done", o_layer_done, 0);
    check("rst_addr", o_wr_addr, 0);
    check("rst_data", o_wr_data, 0);
    check("rst_mask", o_wr_mask, 0);
    check("rst_ovf", o_overflow, 0);
    rst = 1'b1;
    tick();

    // two writes of 100>>>2, plus 2-cycle latency
    i_shift = 4'd2;
    set_all(100);
    start_layer(13'h010, 8'd2, 8'd1, 5'd1);
    ev(8'hFF, 1);
    check("lat_c1_wr_en", o_wr_en, 0);
    tick();
    check("lat_c2_wr_en", o_wr_en, 1);
    check("lat_c2_addr", o_wr_addr, 13'h010);
    ev(8'hFF, 1);
    wait_done("basic_done", 1);
    check("basic_nwr", lg_addr.size(), 2);
    check("basic_addr1", lg_addr[1], 13'h011);
    check("basic_data1", lg_data[1], 64'h1919191919191919);

    // saturation and relu
    i_shift = 4'd0;
    start_layer(13'h100, 8'd3, 8'd1, 5'd1);
    lv = '{-300, 5000, 100, -1, 127, 128, -128, -129};
    i_relu = 0;
    ev(8'hFF, 1);
    i_relu = 1;
    ev(8'hFF, 1);
    i_relu = 0;
    set_all(5000);
    ev(8'hFF, 1);
    wait_done("sat_done", 2);
    check("sat_data0", lg_data[2], 64'h80807F7FFF647F80);
    check("relu_data", lg_data[3], 64'h00007F7F00647F00);
    check("pos_sat", lg_data[4], 64'h7F7F7F7F7F7F7F7F);

    // partial lane enable
    i_shift = 4'd2;
    set_all(100);
    start_layer(13'h200, 8'd1, 8'd2, 5'd1);
    ev(8'hFF, 1);
    ev(8'h07, 1);
    wait_done("mask_done", 3);
    check("mask_val", lg_mask[6], 8'h07);
    check("mask_data", lg_data[6], 64'h0000000000191919);

    // overflow with stalled buffer
    i_wr_ready = 1'b0;
    start_layer(13'h300, 8'd3, 8'd2, 5'd1);
    for (int i = 0; i < 6; i++) begin
      set_all((i + 1) * 4);
      ev(8'hFF, i < FD);
    end
    repeat (3) tick();
    check("ovf_set", o_overflow, 1);
    check("ovf_hold_en", o_wr_en, 1);
    check("ovf_hold_addr", o_wr_addr, 13'h300);
    addr_start_o = 13'h0AA;
    start_calculate = 1'b1;
    tick();
    start_calculate = 1'b0;
    i_wr_ready = 1'b1;
    wait_done("ovf_done", 4);
    check("ovf_sticky", o_overflow, 1);
    check("ovf_nwr", lg_addr.size(), 11);
    check("ovf_last_addr", lg_addr[10], 13'h303);
    check("ovf_last_data", lg_data[10], 64'h0404040404040404);

    // address wrap
    start_layer(13'h1FFF, 8'd2, 8'd1, 5'd1);
    check("ovf_cleared", o_overflow, 0);
    ev(8'hFF, 1);
    ev(8'hFF, 1);
    wait_done("wrap_done", 5);
    check("wrap_a0", lg_addr[11], 13'h1FFF);
    check("wrap_a1", lg_addr[12], 13'h0000);

    // zero target
    start_layer(13'h050, 8'd0, 8'd1, 5'd1);
    check("zt_c1", o_layer_done, 0);
    tick();
    check("zt_c2", o_layer_done, 0);
    tick();
    check("zt_c3", o_layer_done, 1);
    tick();
    check("zt_c4", o_layer_done, 0);
    check("zt_cnt", done_cnt, 6);
    check("zt_nwr", lg_addr.size(), 13);

    // wrong mode and idle events ignored
    mode = 4'd5;
    start_calculate = 1'b1;
    tick();
    start_calculate = 1'b0;
    mode = 4'd6;
    ev(8'hFF, 0);
    repeat (6) tick();
    check("idle_done", done_cnt, 6);
    check("idle_nwr", lg_addr.size(), 13);

    // reset with pending entries
    i_wr_ready = 1'b0;
    start_layer(13'h400, 8'd4, 8'd1, 5'd1);
    ev(8'hFF, 1);
    ev(8'hFF, 1);
    repeat (2) tick();
    check("pend_wr_en", o_wr_en, 1);
    rst = 1'b0;
    ex_addr.delete();
    ex_data.delete();
    ex_mask.delete();
    tick();
    check("mrst_wr_en", o_wr_en, 0);
    check("mrst_addr", o_wr_addr, 0);
    check("mrst_data", o_wr_data, 0);
    rst = 1'b1;
    i_wr_ready = 1'b1;
    repeat (10) tick();
    check("mrst_nwr", lg_addr.size(), 13);
    check("mrst_done", done_cnt, 6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
